// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Holds the default SRAM geometry, the arbiter state encoding and a log2 helper.
package sram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request found searching upward from start_i, wrapping.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    logic found;
    int   j;
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(start_i) + k) % N;
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM.
// Supports capped locked bursts and returns reads with a one-hot valid strobe.
module sram_arbiter #(
  parameter int NREQ      = 2,
  parameter int MAX_BURST = 4,
  parameter int ADDR_W    = sram_arb_pkg::ADDR_W,
  parameter int DATA_W    = sram_arb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ-1:0]        lock,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_di,
  input  logic [DATA_W-1:0]      sram_do
);
  import sram_arb_pkg::*;

  localparam int LW = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
  localparam int BW = clog2(MAX_BURST + 1);

  state_e          state_q, state_d;
  logic [LW-1:0]   last_q, last_d;
  logic [LW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;

  logic [LW-1:0]   start;
  logic [NREQ-1:0] pick;
  logic [LW-1:0]   pick_idx;
  logic [LW-1:0]   win;
  logic            own_hit;
  logic            any;

  function automatic logic [LW-1:0] inc(input logic [LW-1:0] x);
    return (x == LW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  assign start = (state_q == OWN) ? inc(owner_q) : inc(last_q);

  rr_pick #(
    .N  (NREQ),
    .IW (LW)
  ) u_pick (
    .req_i   (req),
    .start_i (start),
    .pick_o  (pick),
    .idx_o   (pick_idx)
  );

  assign own_hit = (state_q == OWN) && req[owner_q];
  assign win     = own_hit ? owner_q : pick_idx;
  // Reset forces the SRAM side idle even while requests are held.
  assign any     = (|req) && !reset;

  always_comb begin
    gnt       = '0;
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    sram_addr = '0;
    sram_di   = '0;
    if (any) begin
      gnt       = own_hit ? (NREQ'(1) << owner_q) : pick;
      sram_en   = 1'b1;
      sram_we   = we[win];
      sram_addr = addr[win*ADDR_W +: ADDR_W];
      sram_di   = wdata[win*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    bcnt_d   = bcnt_q;
    rvalid_d = gnt & ~we;
    if (any) begin
      last_d = win;
      unique case (state_q)
        ARB: begin
          if (lock[win]) begin
            state_d = OWN;
            owner_d = win;
            bcnt_d  = BW'(1);
          end
        end
        OWN: begin
          if (own_hit && lock[win] &&
              (int'(bcnt_q) + 1 < MAX_BURST)) begin
            bcnt_d = bcnt_q + 1'b1;
          end else begin
            state_d = ARB;
            bcnt_d  = '0;
          end
        end
        default: begin
          state_d = ARB;
          bcnt_d  = '0;
        end
      endcase
    end else begin
      state_d = ARB;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB;
      last_q   <= LW'(NREQ - 1);
      owner_q  <= '0;
      bcnt_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      bcnt_q   <= bcnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = sram_do;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural SRAM.
// Covers alternation, write-then-read, burst cap, lock drop, reset and NREQ=3.
module tb_sram_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        sram_en, sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_di, sram_do;

  logic [2:0]  req3, we3, lock3;
  logic [47:0] addr3;
  logic [95:0] wdata3;
  logic [2:0]  gnt3, rvalid3;
  logic [31:0] rdata3;
  logic        sram_en3, sram_we3;
  logic [15:0] sram_addr3;
  logic [31:0] sram_di3, sram_do3;

  logic [31:0] mem [0:65535];

  int n_chk;
  int n_err;

  sram_arbiter #(.NREQ(2), .MAX_BURST(4)) u_dut (
    .clk       (clk),
    .reset     (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .sram_en   (sram_en),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_di   (sram_di),
    .sram_do   (sram_do)
  );

  sram_arbiter #(.NREQ(3), .MAX_BURST(4)) u_dut3 (
    .clk       (clk),
    .reset     (rst),
    .req       (req3),
    .we        (we3),
    .lock      (lock3),
    .addr      (addr3),
    .wdata     (wdata3),
    .gnt       (gnt3),
    .rvalid    (rvalid3),
    .rdata     (rdata3),
    .sram_en   (sram_en3),
    .sram_we   (sram_we3),
    .sram_addr (sram_addr3),
    .sram_di   (sram_di3),
    .sram_do   (sram_do3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_di;
      else sram_do <= mem[sram_addr];
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [1:0]  prev;
  logic [1:0]  exp3 [10];
  logic [15:0] a0_prev;

  initial begin
    n_chk   = 0;
    n_err   = 0;
    sram_do = '0;
    for (int a = 0; a < 256; a++) mem[a] = 32'hC0DE_0000 | a;
    exp3 = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    rst    = 1'b1;
    req    = 2'b11;
    we     = 2'b00;
    lock   = 2'b00;
    addr   = {16'h0020, 16'h0010};
    wdata  = '0;
    req3   = '0;
    we3    = '0;
    lock3  = '0;
    addr3  = '0;
    wdata3 = '0;
    sram_do3 = '0;

    #1;
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst en", 32'(sram_en), 32'h0);
    check("rst addr", 32'(sram_addr), 32'h0);
    check("rst rvalid", 32'(rvalid), 32'h0);
    tick();
    rst  = 1'b0;
    prev = 2'b00;

    for (int i = 0; i < 6; i++) begin
      #1;
      check("t1 gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
      check("t1 addr", 32'(sram_addr), (i % 2 == 0) ? 32'h10 : 32'h20);
      check("t1 rvalid", 32'(rvalid), 32'(prev));
      if (prev == 2'b01) check("t1 rdata", rdata, 32'hC0DE_0010);
      if (prev == 2'b10) check("t1 rdata", rdata, 32'hC0DE_0020);
      prev = (i % 2 == 0) ? 2'b01 : 2'b10;
      tick();
    end
    req = 2'b00;
    #1;
    check("t1 last rvalid", 32'(rvalid), 32'h2);
    check("t1 last rdata", rdata, 32'hC0DE_0020);
    check("idle gnt", 32'(gnt), 32'h0);
    check("idle en", 32'(sram_en), 32'h0);
    tick();

    req = 2'b01;
    we  = 2'b01;
    addr[15:0]  = 16'h1234;
    wdata[31:0] = 32'hDEAD_BEEF;
    #1;
    check("t2 wr gnt", 32'(gnt), 32'h1);
    check("t2 wr we", 32'(sram_we), 32'h1);
    check("t2 wr addr", 32'(sram_addr), 32'h1234);
    check("t2 wr di", sram_di, 32'hDEAD_BEEF);
    tick();
    req = 2'b10;
    we  = 2'b00;
    addr[31:16] = 16'h1234;
    #1;
    check("t2 rd gnt", 32'(gnt), 32'h2);
    check("t2 rd we", 32'(sram_we), 32'h0);
    check("t2 wr no rvalid", 32'(rvalid), 32'h0);
    tick();
    req = 2'b00;
    #1;
    check("t2 rvalid", 32'(rvalid), 32'h2);
    check("t2 rdata", rdata, 32'hDEAD_BEEF);
    tick();

    req  = 2'b11;
    lock = 2'b01;
    addr = {16'h0020, 16'h0000};
    prev = 2'b00;
    a0_prev = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t3 gnt", 32'(gnt), 32'(exp3[i]));
      check("t3 rvalid", 32'(rvalid), 32'(prev));
      if (prev == 2'b01)
        check("t3 rdata", rdata, 32'hC0DE_0000 | 32'(a0_prev));
      prev    = exp3[i];
      a0_prev = addr[15:0];
      tick();
      if (exp3[i] == 2'b01) addr[15:0] = addr[15:0] + 16'h1;
    end
    req  = 2'b00;
    lock = 2'b00;
    tick();

    req  = 2'b11;
    lock = 2'b01;
    #1;
    check("t4 own1", 32'(gnt), 32'h1);
    tick();
    #1;
    check("t4 own2", 32'(gnt), 32'h1);
    tick();
    req  = 2'b10;
    lock = 2'b10;
    #1;
    check("t4 drop", 32'(gnt), 32'h2);
    tick();
    req  = 2'b11;
    lock = 2'b10;
    #1;
    check("t4 arb", 32'(gnt), 32'h1);
    tick();
    req  = 2'b00;
    lock = 2'b00;
    tick();

    req  = 2'b10;
    lock = 2'b10;
    #1;
    check("t5 gnt1", 32'(gnt), 32'h2);
    tick();
    req = 2'b11;
    #1;
    check("t5 own", 32'(gnt), 32'h2);
    check("t5 rvalid", 32'(rvalid), 32'h2);
    rst = 1'b1;
    #1;
    check("t5 rst gnt", 32'(gnt), 32'h0);
    check("t5 rst en", 32'(sram_en), 32'h0);
    check("t5 rst rvalid", 32'(rvalid), 32'h0);
    tick();
    check("t5 rvalid held", 32'(rvalid), 32'h0);
    rst = 1'b0;
    #1;
    check("t5 prio", 32'(gnt), 32'h1);
    tick();
    req  = 2'b00;
    lock = 2'b00;
    #1;
    check("t5 rvalid after", 32'(rvalid), 32'h1);
    tick();

    req3 = 3'b100;
    #1;
    check("t6 req2", 32'(gnt3), 32'h4);
    tick();
    req3 = 3'b011;
    #1;
    check("t6 wrap0", 32'(gnt3), 32'h1);
    tick();
    #1;
    check("t6 next1", 32'(gnt3), 32'h2);
    tick();
    #1;
    check("t6 wrap again", 32'(gnt3), 32'h1);
    tick();
    req3 = 3'b000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
